// File: rtl/branch_pdt_pkg.sv
// Shared widths and 2-bit counter encodings for the branch predictor (BTB + bimodal counters).
package branch_pdt_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_W       = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } pdt_cnt_e;

endpackage

// File: rtl/branch_pdt_sat_cnt.sv
// Two-bit saturating counter next-state, used on the predictor update path.
module pdt_sat_cnt
  import branch_pdt_pkg::*;
(
  input  pdt_cnt_e cnt,
  input  logic     taken,
  output pdt_cnt_e cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    unique case (cnt)
      CNT_SNT: cnt_nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_nxt = taken ? CNT_ST  : CNT_WT;
      default: cnt_nxt = cnt;
    endcase
  end

endmodule

// File: rtl/branch_pdt.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch prediction, ID-side update,
// and a registered copy of the prediction aligned with the instruction entering ID.
module branch_pdt
  import branch_pdt_pkg::*;
#(
  parameter int PDT_ENTRIES = 16,
  parameter int PDT_IDX_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             stall,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   upd_valid_i,
  input  logic [INST_ADDR_W-1:0] upd_pc_i,
  input  logic                   upd_taken_i,
  input  logic [REG_W-1:0]       upd_target_i,
  output logic                   branch_or_not,
  output logic [INST_ADDR_W-1:0] pdt_pc,
  output logic                   pdt_taken_o,
  output logic [INST_ADDR_W-1:0] pdt_target_o,
  output logic [31:0]            mispdt_cnt_o
);

  localparam int TAG_W = INST_ADDR_W - PDT_IDX_W - 2;
  localparam int TGT_W = INST_ADDR_W - 2;

  logic                 valid_q  [PDT_ENTRIES];
  logic     [TAG_W-1:0] tag_q    [PDT_ENTRIES];
  logic     [TGT_W-1:0] target_q [PDT_ENTRIES];
  pdt_cnt_e             cnt_q    [PDT_ENTRIES];

  logic [PDT_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;

  logic [PDT_IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0]     upd_tag;
  logic                 upd_acc;
  logic                 upd_hit;
  logic                 upd_pred;
  logic                 upd_mis;
  pdt_cnt_e             cnt_nxt;

  logic                   pdt_taken_p1;
  logic [INST_ADDR_W-1:0] pdt_target_p1;
  logic [31:0]            mispdt_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_pc_i[1:0], upd_target_i[1:0], stall[5:3], stall[0]};

  // Stage p0: combinational lookup on the registered table
  assign lk_idx = pc[PDT_IDX_W+1:2];
  assign lk_tag = pc[INST_ADDR_W-1:PDT_IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && (ce == CHIP_ENABLE);

  assign branch_or_not = lk_hit && cnt_q[lk_idx][1];
  assign pdt_pc        = branch_or_not ? {target_q[lk_idx], 2'b00} : pc + 32'd4;

  // Update path: the prediction the table would have made for upd_pc_i decides misprediction
  assign upd_idx  = upd_pc_i[PDT_IDX_W+1:2];
  assign upd_tag  = upd_pc_i[INST_ADDR_W-1:PDT_IDX_W+2];
  assign upd_acc  = upd_valid_i && !stall[2];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_pred = upd_hit && cnt_q[upd_idx][1];
  assign upd_mis  = (upd_taken_i != upd_pred) ||
                    (upd_taken_i && upd_pred && (target_q[upd_idx] != upd_target_i[INST_ADDR_W-1:2]));

  pdt_sat_cnt u_sat_cnt (
    .cnt     (cnt_q[upd_idx]),
    .taken   (upd_taken_i),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < PDT_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (upd_acc) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= cnt_nxt;
        if (upd_taken_i) target_q[upd_idx] <= upd_target_i[INST_ADDR_W-1:2];
      end else if (upd_taken_i) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i[INST_ADDR_W-1:2];
        cnt_q[upd_idx]    <= CNT_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mispdt_cnt_q <= '0;
    end else if (upd_acc && upd_mis) begin
      mispdt_cnt_q <= mispdt_cnt_q + 32'd1;
    end
  end

  // Stage p1: prediction travelling with the instruction into ID
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pdt_taken_p1  <= 1'b0;
      pdt_target_p1 <= '0;
    end else if (!stall[1]) begin
      pdt_taken_p1  <= branch_or_not;
      pdt_target_p1 <= pdt_pc;
    end else if (!stall[2]) begin
      pdt_taken_p1  <= 1'b0;
      pdt_target_p1 <= '0;
    end
  end

  assign pdt_taken_o  = pdt_taken_p1;
  assign pdt_target_o = pdt_target_p1;
  assign mispdt_cnt_o = mispdt_cnt_q;

endmodule
